sprite_blit_ctrl: RTL

SPRITE_BLIT_CTRL -- requirements
Module: sprite_blit_ctrl

---
 rtl/sprite_blit_ctrl_pkg.sv | 18 +
 rtl/sprite_blit_ctrl_frame_tick_gen.sv | 40 ++++
 rtl/sprite_blit_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sprite_blit_ctrl_pkg.sv
// Shared constants and FSM encoding for the bouncing-sprite blitter.
package sprite_blit_ctrl_pkg;

    localparam int         SCREEN_W   = 160;
    localparam int         SCREEN_H   = 120;
    localparam logic [2:0] COLOUR_FG  = 3'b111;
    localparam logic [2:0] COLOUR_BG  = 3'b000;
    localparam logic [7:0] POS_X_INIT = 8'd0;
    localparam logic [6:0] POS_Y_INIT = 7'd60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        MOVE  = 2'd2,
        DRAW  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/sprite_blit_ctrl_frame_tick_gen.sv
// Frame-rate divider: one-cycle start pulse on every FRAMES_PER_STEP-th frame tick.
module frame_tick_gen
    import sprite_blit_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = 833334,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    output logic start
);

    logic [31:0] tick_cnt;
    logic [31:0] frame_cnt;
    logic        tick;

    assign tick = (tick_cnt == 32'(TICK_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
            start     <= 1'b0;
        end else begin
            start <= 1'b0;
            if (tick) begin
                tick_cnt <= '0;
                if (frame_cnt == 32'(FRAMES_PER_STEP - 1)) begin
                    frame_cnt <= '0;
                    start     <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 32'd1;
                end
            end else begin
                tick_cnt <= tick_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Erase / move / redraw of a bouncing 1-bpp sprite into the vga_adapter framebuffer.
module sprite_blit_ctrl
    import sprite_blit_ctrl_pkg::*;
#(
    parameter int SPR_W           = 16,
    parameter int SPR_H           = 16,
    parameter int TICK_DIV        = 833334,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                             CLOCK_50,
    input  logic                             reset_n,
    input  logic                             enable,
    output logic [$clog2(SPR_W*SPR_H)-1:0]   rom_addr,
    input  logic                             rom_q,
    output logic [7:0]                       x,
    output logic [6:0]                       y,
    output logic [2:0]                       colour,
    output logic                             plot,
    output logic                             busy
);

    localparam int         AW     = $clog2(SPR_W * SPR_H);
    localparam logic [7:0] X_MAX  = 8'(SCREEN_W - SPR_W);
    localparam logic [6:0] Y_MAX  = 7'(SCREEN_H - SPR_H);
    localparam logic [7:0] I_LAST = 8'(SPR_W - 1);
    localparam logic [6:0] J_LAST = 7'(SPR_H - 1);

    blit_state_t state;
    logic        start;
    logic [7:0]  pos_x;
    logic [6:0]  pos_y;
    logic        dir_x;      // 1 = moving towards larger coordinates
    logic        dir_y;
    logic [7:0]  pix_i;
    logic [6:0]  pix_j;
    logic [7:0]  next_i;
    logic [6:0]  next_j;
    logic        last_pix;
    logic        addr_done;
    logic [2:0]  colour_r;
    logic        vld_p1;

    frame_tick_gen #(
        .TICK_DIV        (TICK_DIV),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_frame_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .start    (start)
    );

    function automatic logic [AW-1:0] pix_addr(input logic [7:0] i, input logic [6:0] j);
        return AW'(32'(j) * SPR_W + 32'(i));
    endfunction

    assign last_pix = (pix_i == I_LAST) && (pix_j == J_LAST);
    assign next_i   = (pix_i == I_LAST) ? 8'd0 : pix_i + 8'd1;
    assign next_j   = (pix_i == I_LAST) ? pix_j + 7'd1 : pix_j;

    // ROM data arrives one cycle after its address, so draw colour is taken straight from rom_q
    assign colour = vld_p1 ? (rom_q ? COLOUR_FG : COLOUR_BG) : colour_r;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pos_x     <= POS_X_INIT;
            pos_y     <= POS_Y_INIT;
            dir_x     <= 1'b1;
            dir_y     <= 1'b0;
            pix_i     <= '0;
            pix_j     <= '0;
            addr_done <= 1'b0;
            rom_addr  <= '0;
            x         <= '0;
            y         <= '0;
            colour_r  <= COLOUR_BG;
            plot      <= 1'b0;
            vld_p1    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot   <= 1'b0;
                    vld_p1 <= 1'b0;
                    if (start && enable) begin
                        state    <= ERASE;
                        busy     <= 1'b1;
                        pix_i    <= '0;
                        pix_j    <= '0;
                        x        <= pos_x;
                        y        <= pos_y;
                        colour_r <= COLOUR_BG;
                        plot     <= 1'b1;
                    end
                end
                ERASE: begin
                    if (last_pix) begin
                        state <= MOVE;
                        plot  <= 1'b0;
                    end else begin
                        pix_i <= next_i;
                        pix_j <= next_j;
                        x     <= pos_x + next_i;
                        y     <= pos_y + next_j;
                    end
                end
                MOVE: begin
                    state     <= DRAW;
                    pix_i     <= '0;
                    pix_j     <= '0;
                    addr_done <= 1'b0;
                    rom_addr  <= '0;
                    // A step that would leave the screen reverses and steps back instead
                    if (dir_x) begin
                        if (pos_x == X_MAX) begin dir_x <= 1'b0; pos_x <= pos_x - 8'd1; end
                        else pos_x <= pos_x + 8'd1;
                    end else begin
                        if (pos_x == 8'd0) begin dir_x <= 1'b1; pos_x <= pos_x + 8'd1; end
                        else pos_x <= pos_x - 8'd1;
                    end
                    if (dir_y) begin
                        if (pos_y == Y_MAX) begin dir_y <= 1'b0; pos_y <= pos_y - 7'd1; end
                        else pos_y <= pos_y + 7'd1;
                    end else begin
                        if (pos_y == 7'd0) begin dir_y <= 1'b1; pos_y <= pos_y + 7'd1; end
                        else pos_y <= pos_y - 7'd1;
                    end
                end
                DRAW: begin
                    if (addr_done) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        plot   <= 1'b0;
                        vld_p1 <= 1'b0;
                    end else begin
                        x      <= pos_x + pix_i;
                        y      <= pos_y + pix_j;
                        plot   <= 1'b1;
                        vld_p1 <= 1'b1;
                        if (last_pix) begin
                            addr_done <= 1'b1;
                        end else begin
                            pix_i    <= next_i;
                            pix_j    <= next_j;
                            rom_addr <= pix_addr(next_i, next_j);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
